// File: rtl/gen_mat_pkg.sv
// gen_mat_pkg -- shared types and constants for the matrix fill memory.
//   state_e     : fill controller states (IDLE, FILL, DONE)
//   MODE_*      : fill pattern encodings for the 2-bit mode input
//   LFSR_TAPS   : 32-bit Galois LFSR feedback taps
//   lfsr_next() : one Galois LFSR step (shift right, xor taps when bit 0 is set)
package gen_mat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] MODE_RAMP  = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_INDEX = 2'd3;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/gen_mat_ram.sv
// gen_mat_ram -- simple dual-port RAM, DATA_W x 2**ADDR_W.
// One synchronous write port and one registered read port. The array itself
// is not reset; only the read output register is.
// Ports:
//   clk     : clock
//   reset   : asynchronous active-low reset (read register only)
//   wr_en   : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read enable; rd_data updates on the next edge
//   rd_addr : read address
//   rd_data : registered read data, held when rd_en is low
module gen_mat_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset branch so it can map onto block RAM;
  // contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // NOTE: sequential state is always assigned with <= so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/gen_mat_mem.sv
// gen_mat_mem -- fills a ROWS x COLS matrix into RAM with a selectable pattern,
// then serves reads from the filled RAM.
// Optional feature macro: GEN_MAT_MEM_LFSR_EN (mode 2 writes a 32-bit Galois
// LFSR sequence; without it mode 2 is a ramp and no LFSR logic exists).
// Ports:
//   clk      : clock
//   reset    : asynchronous active-low reset
//   start    : single-cycle fill request (accepted in IDLE or DONE)
//   mode     : fill pattern, sampled with start (0 ramp, 1 const, 2 lfsr, 3 index)
//   seed     : pattern seed, sampled with start
//   rd_en    : read request, honoured only in DONE
//   rd_addr  : read address
//   rd_data  : read data, one cycle after an accepted read
//   rd_valid : rd_data qualifier
//   busy     : high while filling
//   wr_done  : matrix fully written
module gen_mat_mem
  import gen_mat_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int ROWS   = 2,
  parameter int COLS   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              wr_done
);

  localparam int TOTAL = ROWS * COLS;
  localparam int HALF  = DATA_W / 2;

  if (TOTAL == 0 || TOTAL > 2**ADDR_W) begin : g_bad_size
    $error("gen_mat_mem: ROWS*COLS must be in 1..2**ADDR_W");
  end

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] cnt, row, col;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] wr_data;
  logic              start_ok, last_wr, rd_ok;

  assign start_ok = start && (state != FILL);
  assign last_wr  = (state == FILL) && (cnt == ADDR_W'(TOTAL - 1));
  assign rd_ok    = rd_en && (state == DONE);
  assign busy     = (state == FILL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = FILL;
      FILL:       if (last_wr) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Fill counter plus row/col trackers; row/col avoid a divider for mode 3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      row     <= '0;
      col     <= '0;
      mode_q  <= MODE_RAMP;
      seed_q  <= '0;
      wr_done <= 1'b0;
    end else if (start_ok) begin
      mode_q  <= mode;
      seed_q  <= seed;
      cnt     <= '0;
      row     <= '0;
      col     <= '0;
      wr_done <= 1'b0;
    end else if (state == FILL) begin
      cnt <= cnt + ADDR_W'(1);
      if (col == ADDR_W'(COLS - 1)) begin
        col <= '0;
        row <= row + ADDR_W'(1);
      end else begin
        col <= col + ADDR_W'(1);
      end
      if (last_wr) wr_done <= 1'b1;
    end
  end

`ifdef GEN_MAT_MEM_LFSR_EN
  logic [31:0] lfsr;

  // Loaded on start so the first write uses the seed state itself; a zero
  // seed would lock the LFSR, so it is replaced by 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              lfsr <= 32'd1;
    else if (start_ok)       lfsr <= (seed == '0) ? 32'd1 : 32'(seed);
    else if (state == FILL)  lfsr <= lfsr_next(lfsr);
  end
`endif

  always_comb begin
    wr_data = seed_q + DATA_W'(cnt);
    case (mode_q)
      MODE_CONST: wr_data = seed_q;
      MODE_INDEX: wr_data = DATA_W'({HALF'(row), HALF'(col)});
`ifdef GEN_MAT_MEM_LFSR_EN
      MODE_LFSR:  wr_data = DATA_W'(lfsr);
`endif
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_valid <= 1'b0;
    else        rd_valid <= rd_ok;
  end

  gen_mat_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (state == FILL),
    .wr_addr (cnt),
    .wr_data (wr_data),
    .rd_en   (rd_ok),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: doc/gen_mat_mem.md
GEN_MAT_MEM -- requirements
Module: gen_mat_mem

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, word width.
REQ-002 The block SHALL take parameter ADDR_W, default 8, address width; RAM depth = 2**ADDR_W.
REQ-003 The block SHALL take parameter ROWS, default 2, matrix row count (N).
REQ-004 The block SHALL take parameter COLS, default 4, matrix column count (P).
REQ-005 The block SHALL have port clk, input, 1, sole clock.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1, single-cycle fill request.
REQ-008 The block SHALL have port mode, input, 2, fill pattern select, sampled with start.
REQ-009 The block SHALL have port seed, input, DATA_W, pattern seed, sampled with start.
REQ-010 The block SHALL have port rd_en, input, 1, read request.
REQ-011 The block SHALL have port rd_addr, input, ADDR_W, read address.
REQ-012 The block SHALL have port rd_data, output, DATA_W, read data.
REQ-013 The block SHALL have port rd_valid, output, 1, rd_data qualifier.
REQ-014 The block SHALL have port busy, output, 1, fill in progress.
REQ-015 The block SHALL have port wr_done, output, 1, matrix fully written.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, DONE.
REQ-017 In IDLE or DONE, start=1 at edge k SHALL latch mode/seed, clear the fill counter and wr_done, and enter FILL.
REQ-018 In FILL, one word SHALL be written per cycle at addresses 0..ROWS*COLS-1, the first write on edge k+1 and the last on edge k+ROWS*COLS.
REQ-019 wr_done SHALL rise and the FSM SHALL enter DONE on the edge of the last write; busy SHALL be high exactly while in FILL.
REQ-020 start in FILL SHALL be ignored; the fill SHALL continue uninterrupted.
REQ-021 Write data by mode: 0 ramp = seed+addr (mod 2**DATA_W); 1 constant = seed; 2 LFSR; 3 index = {row, col}, each DATA_W/2 bits, with addr = row*COLS+col.
REQ-022 Addresses >= ROWS*COLS SHALL never be written.
REQ-023 rd_en=1 in DONE SHALL return RAM[rd_addr] on rd_data with rd_valid=1 one cycle later.
REQ-024 rd_en in IDLE or FILL SHALL produce rd_valid=0 and leave rd_data unchanged.
REQ-025 A read in DONE on the same edge start is accepted SHALL complete normally with the pre-refill data.
REQ-026 ROWS*COLS > 2**ADDR_W or ROWS*COLS = 0 SHALL be an elaboration-time error.

Reset
REQ-027 reset low SHALL force IDLE, clear the fill counter, and drive rd_data=0, rd_valid=0, busy=0, wr_done=0, with no clock required.
REQ-028 reset low mid-FILL SHALL abort the fill; after release, wr_done SHALL stay 0 until a new start completes.
REQ-029 RAM contents SHALL NOT be reset; they are undefined until the first completed fill.

Configuration
REQ-030 With GEN_MAT_MEM_LFSR_EN defined, mode 2 SHALL write a 32-bit Galois LFSR sequence:
- state loaded from seed, or 1 if seed=0;
- advanced once per write with the package taps;
- the first write uses the loaded state;
- the low DATA_W bits are written.
REQ-031 Without GEN_MAT_MEM_LFSR_EN, mode 2 SHALL behave identically to mode 0 and no LFSR logic SHALL be present.

Structure
REQ-032 Package gen_mat_pkg SHALL hold the FSM state typedef, the mode encoding constants and the LFSR tap constant 32'h8020_0003.
REQ-033 Storage SHALL be the sub-module gen_mat_ram:
- simple dual-port: one write port, one registered read port;
- DATA_W x 2**ADDR_W;
- no reset on the array.

Verification
REQ-034 Reset, then start with mode=0 and seed=100 (2x4) -> busy high 8 cycles, wr_done high 8 cycles after start, reads of addresses 0..7 return 100..107 with 1-cycle latency.
REQ-035 mode=3 fill, then read address 5 -> rd_data = {16'd1, 16'd1}; read address 7 -> {16'd1, 16'd3}.
REQ-036 rd_en during FILL -> rd_valid=0; start pulsed again at cycle 3 of FILL -> ignored, wr_done at the original cycle.
REQ-037 reset low at cycle 4 of FILL -> all outputs 0 immediately; after release, wr_done=0 until a new start completes.
REQ-038 Re-start from DONE with mode=1 and seed=32'hDEAD_BEEF -> wr_done drops next edge; after the fill, all 8 words read 32'hDEAD_BEEF and address 8 keeps its prior value.
REQ-039 mode=2 with seed=0 -> with GEN_MAT_MEM_LFSR_EN, address 0 = 1 and address 1 = 32'h8020_0003; without the macro, it matches ramp mode (address 0 = 0, address 1 = 1).
